// File: rtl/acl_spi_reader.sv
// acl_spi_reader
//   SPI master (mode 3) that configures an ADXL345-class accelerometer and then
//   reads one axis every SAMPLE_PERIOD clocks. The sample is presented as the
//   10-bit two's-complement word used by the VGA/game logic.
//
// Ports
//   clk        100 MHz system clock
//   rst        asynchronous reset, active low
//   SDI        MISO from the sensor
//   SDO        MOSI to the sensor
//   SCLK       SPI clock, idles high
//   SS         chip select, active low
//   ACL_OUT    latest axis sample, two's complement
//   data_valid one-cycle pulse coincident with each ACL_OUT update
//   init_done  high once both configuration writes have completed
module acl_spi_reader #(
  parameter int CLK_DIV       = 50,
  parameter int SAMPLE_PERIOD = 100000,
  parameter int AXIS          = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SDI,
  output logic       SDO,
  output logic       SCLK,
  output logic       SS,
  output logic [9:0] ACL_OUT,
  output logic       data_valid,
  output logic       init_done
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int TMR_W = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SAMPLE_PERIOD - 1);
  // Read command with the read and multibyte bits set, pointing at DATA0 of the axis
  localparam logic [7:0] READ_CMD = (AXIS == 0) ? 8'hF2 : 8'hF4;

  typedef enum logic [2:0] {
    ST_INIT_FMT,
    ST_INIT_PWR,
    ST_WAIT,
    ST_READ,
    ST_UPDATE
  } state_t;

  // Shift engine phases. Every phase except IDLE lasts exactly CLK_DIV clocks;
  // the two GAP phases hold SS high between frames.
  typedef enum logic [2:0] {
    PH_IDLE,
    PH_LEAD,
    PH_LOW,
    PH_HIGH,
    PH_TRAIL,
    PH_GAP1,
    PH_GAP2
  } phase_t;

  state_t            r_state;
  state_t            w_stateNext;
  phase_t            r_phase;
  phase_t            w_phaseNext;

  logic [DIV_W-1:0]  r_divCnt;
  logic [4:0]        r_bitCnt;
  logic [4:0]        r_len;
  logic [23:0]       r_shOut;
  logic [15:0]       r_shIn;
  logic              r_sclk;
  logic              r_ss;
  logic              r_sdo;

  logic [9:0]        r_acl;
  logic              r_valid;
  logic              r_initDone;
  logic [TMR_W-1:0]  r_timer;

  logic              w_start;
  logic [23:0]       w_txWord;
  logic [4:0]        w_txLen;
  logic              w_divEnd;
  logic              w_lastBit;
  logic              w_engDone;
  logic              w_engIdle;
  logic              w_tick;
  logic              w_unusedSignExt;

  assign w_divEnd  = (r_divCnt == DIV_LAST);
  assign w_lastBit = (r_bitCnt == (r_len - 5'd1));
  assign w_engDone = (r_phase == PH_TRAIL) && w_divEnd;
  assign w_engIdle = (r_phase == PH_IDLE);
  assign w_tick    = r_initDone && (r_timer == TMR_LAST);

  // DATA1[7:2] only repeats the sign bit, so those bits are never used
  assign w_unusedSignExt = ^r_shIn[7:2];

  // Engine phase sequencing: lead-in, alternating low/high SCLK halves until
  // the last rising edge, trailing half, then the mandatory SS-high gap.
  always_comb begin
    w_phaseNext = r_phase;
    case (r_phase)
      PH_IDLE:  if (w_start)  w_phaseNext = PH_LEAD;
      PH_LEAD:  if (w_divEnd) w_phaseNext = PH_LOW;
      PH_LOW:   if (w_divEnd) w_phaseNext = w_lastBit ? PH_TRAIL : PH_HIGH;
      PH_HIGH:  if (w_divEnd) w_phaseNext = PH_LOW;
      PH_TRAIL: if (w_divEnd) w_phaseNext = PH_GAP1;
      PH_GAP1:  if (w_divEnd) w_phaseNext = PH_GAP2;
      PH_GAP2:  if (w_divEnd) w_phaseNext = PH_IDLE;
      default:  w_phaseNext = PH_IDLE;
    endcase
  end

  // Engine datapath: SCLK falls drive the next MOSI bit, SCLK rises sample
  // MISO. Only the last 16 received bits are kept, which after a read are
  // exactly DATA0 followed by DATA1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase  <= PH_IDLE;
      r_divCnt <= '0;
      r_bitCnt <= '0;
      r_len    <= '0;
      r_shOut  <= '0;
      r_shIn   <= '0;
      r_sclk   <= 1'b1;
      r_ss     <= 1'b1;
      r_sdo    <= 1'b0;
    end else begin
      r_phase <= w_phaseNext;
      if (r_phase == PH_IDLE) begin
        r_divCnt <= '0;
        if (w_start) begin
          r_ss     <= 1'b0;
          r_bitCnt <= '0;
          r_len    <= w_txLen;
          r_shOut  <= w_txWord;
        end
      end else begin
        r_divCnt <= w_divEnd ? '0 : r_divCnt + 1'b1;
        if (w_divEnd) begin
          case (r_phase)
            PH_LEAD, PH_HIGH: begin
              r_sclk  <= 1'b0;
              r_sdo   <= r_shOut[23];
              r_shOut <= {r_shOut[22:0], 1'b0};
            end
            PH_LOW: begin
              r_sclk   <= 1'b1;
              r_shIn   <= {r_shIn[14:0], SDI};
              r_bitCnt <= r_bitCnt + 5'd1;
            end
            PH_TRAIL: begin
              r_ss  <= 1'b1;
              r_sdo <= 1'b0;
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

  // Main state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_INIT_FMT;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Main sequencing. The init states launch their write as soon as the engine
  // is idle; since the engine is busy until well after each state is left,
  // each write is issued exactly once. A sample tick that arrives while the
  // engine is busy is simply lost.
  always_comb begin
    w_stateNext = r_state;
    w_start     = 1'b0;
    w_txWord    = {8'h31, 8'h00, 8'h00};
    w_txLen     = 5'd16;
    case (r_state)
      ST_INIT_FMT: begin
        w_start = w_engIdle;
        if (w_engDone) w_stateNext = ST_INIT_PWR;
      end
      ST_INIT_PWR: begin
        w_txWord = {8'h2D, 8'h08, 8'h00};
        w_start  = w_engIdle;
        if (w_engDone) w_stateNext = ST_WAIT;
      end
      ST_WAIT: begin
        w_txWord = {READ_CMD, 16'h0000};
        w_txLen  = 5'd24;
        if (w_tick && w_engIdle) begin
          w_start     = 1'b1;
          w_stateNext = ST_READ;
        end
      end
      ST_READ: begin
        if (w_engDone) w_stateNext = ST_UPDATE;
      end
      ST_UPDATE: begin
        w_stateNext = ST_WAIT;
      end
      default: begin
        w_stateNext = ST_INIT_FMT;
      end
    endcase
  end

  // Sample output, init flag and free-running sample timer. The timer only
  // runs after initialisation, so the first read lands one full period after
  // init_done rises.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acl      <= '0;
      r_valid    <= 1'b0;
      r_initDone <= 1'b0;
      r_timer    <= '0;
    end else begin
      r_valid <= (r_state == ST_UPDATE);
      if (r_state == ST_UPDATE) begin
        r_acl <= {r_shIn[1:0], r_shIn[15:8]};
      end
      if ((r_state == ST_INIT_PWR) && w_engDone) begin
        r_initDone <= 1'b1;
      end
      if (r_initDone) begin
        r_timer <= (r_timer == TMR_LAST) ? '0 : r_timer + 1'b1;
      end
    end
  end

  assign SDO        = r_sdo;
  assign SCLK       = r_sclk;
  assign SS         = r_ss;
  assign ACL_OUT    = r_acl;
  assign data_valid = r_valid;
  assign init_done  = r_initDone;

endmodule

// File: tb/tb_acl_spi_reader.sv
// Testbench for acl_spi_reader. Instance A (Y axis, 200-cycle period) talks to
// a behavioural sensor returning table/random data; instance B (X axis,
// 60-cycle period, shorter than a read) checks dropped ticks and frame length.
module tb_acl_spi_reader;

  localparam int CLK_DIV = 2;
  localparam int P_A     = 200;
  localparam int P_B     = 60;
  localparam int CLK_P   = 10;
  localparam int BUDGET  = 5000;

  logic       clk = 1'b0;
  logic       rst;
  logic       sdiA, sdoA, sclkA, ssA, validA, initA;
  logic [9:0] aclA;
  logic       sdiB, sdoB, sclkB, ssB, validB, initB;
  logic [9:0] aclB;

  int nChecks = 0;
  int nPass   = 0;

  always #5 clk = ~clk;

  acl_spi_reader #(.CLK_DIV(CLK_DIV), .SAMPLE_PERIOD(P_A), .AXIS(1)) dutA (
    .clk(clk), .rst(rst), .SDI(sdiA), .SDO(sdoA), .SCLK(sclkA), .SS(ssA),
    .ACL_OUT(aclA), .data_valid(validA), .init_done(initA)
  );

  acl_spi_reader #(.CLK_DIV(CLK_DIV), .SAMPLE_PERIOD(P_B), .AXIS(0)) dutB (
    .clk(clk), .rst(rst), .SDI(sdiB), .SDO(sdoB), .SCLK(sclkB), .SS(ssB),
    .ACL_OUT(aclB), .data_valid(validB), .init_done(initB)
  );

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expVal);
    nChecks++;
    if (obs === expVal) nPass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expVal);
  endtask

  // Sensor data table: the three boundary patterns first, then random bytes
  logic [7:0] d0Tab[16];
  logic [7:0] d1Tab[16];

  task automatic applyStimulus();
    d0Tab[0] = 8'h5A; d1Tab[0] = 8'h03;
    d0Tab[1] = 8'h00; d1Tab[1] = 8'hFE;
    d0Tab[2] = 8'hFF; d1Tab[2] = 8'hFF;
    for (int i = 3; i < 16; i++) begin
      d0Tab[i] = 8'($urandom_range(0, 255));
      d1Tab[i] = 8'($urandom_range(0, 255));
    end
  endtask

  // Instance A bus monitor and sensor model
  int          fCnt, fFalls, periodErr, rdIdx;
  logic [23:0] fBits, slvShift;
  time         fStart, lastFall, initRiseA, initRiseB;
  bit          inFrameA, inFrameB;
  logic [23:0] frBits[$];
  int          frCnt[$];
  int          frFalls[$];
  time         frStart[$];
  time         frEnd[$];
  int          expQ[$];

  initial begin
    rdIdx = 0; periodErr = 0; inFrameA = 0; inFrameB = 0;
  end

  always @(negedge ssA) begin
    inFrameA = 1;
    fBits    = '0;
    fCnt     = 0;
    fFalls   = 0;
    fStart   = $time;
    slvShift = {8'h00, d0Tab[rdIdx % 16], d1Tab[rdIdx % 16]};
  end

  always @(posedge sclkA) if (ssA === 1'b0) begin
    fBits = {fBits[22:0], sdoA};
    fCnt++;
  end

  always @(negedge sclkA) if (ssA === 1'b0) begin
    if (fFalls > 0 && ($time - lastFall) != 4 * CLK_P) periodErr++;
    lastFall = $time;
    fFalls++;
    sdiA     = slvShift[23];
    slvShift = {slvShift[22:0], 1'b0};
  end

  // A complete 24-bit frame is a read; its expected sample is the low two
  // bits of DATA1 as the upper bits above DATA0.
  always @(posedge ssA) if (inFrameA) begin
    inFrameA = 0;
    frBits.push_back(fBits);
    frCnt.push_back(fCnt);
    frFalls.push_back(fFalls);
    frStart.push_back(fStart);
    frEnd.push_back($time);
    if (fCnt == 24) begin
      expQ.push_back((int'(d1Tab[rdIdx % 16]) % 4) * 256 + int'(d0Tab[rdIdx % 16]));
      rdIdx++;
    end
  end

  always @(posedge initA) initRiseA = $time;
  always @(posedge initB) initRiseB = $time;

  // Output monitor for A: every pulse must belong to a completed read, be a
  // single cycle, and ACL_OUT must not move without it.
  logic       prevValid = 1'b0;
  logic [9:0] prevAcl   = '0;
  int         nValid    = 0;

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (validA === 1'b1) begin
        checkOutput("validPulse", 32'(prevValid), 32'd0);
        checkOutput("validHasRead", 32'(expQ.size() > 0), 32'd1);
        if (expQ.size() > 0) checkOutput("aclOut", 32'(aclA), 32'(expQ.pop_front()));
        nValid++;
      end else if (aclA !== prevAcl) begin
        checkOutput("aclHold", 32'(aclA), 32'(prevAcl));
      end
    end
    prevValid = validA;
    prevAcl   = aclA;
  end

  // Instance B monitor: frame length, command byte and start times
  int         bCnt;
  logic [7:0] bCmd;
  int         bCntQ[$];
  logic [7:0] bCmdQ[$];
  time        bStartQ[$];

  always @(negedge ssB) begin
    inFrameB = 1;
    bCnt     = 0;
    bCmd     = '0;
    bStartQ.push_back($time);
  end

  always @(posedge sclkB) if (ssB === 1'b0) begin
    if (bCnt < 8) bCmd = {bCmd[6:0], sdoB};
    bCnt++;
  end

  always @(posedge ssB) if (inFrameB) begin
    inFrameB = 0;
    bCntQ.push_back(bCnt);
    bCmdQ.push_back(bCmd);
  end

  task automatic waitFrames(input int n);
    int cyc = 0;
    while (frBits.size() < n && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("frameWait", 32'(frBits.size() >= n), 32'd1);
  endtask

  task automatic waitValid(input int n);
    int cyc = 0;
    while (nValid < n && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("validWait", 32'(nValid >= n), 32'd1);
  endtask

  task automatic checkInitFrames(input int base);
    logic [23:0] w;
    w = frBits[base];
    checkOutput("fmtWord", 32'(w[15:0]), 32'h3100);
    checkOutput("fmtBits", 32'(frCnt[base]), 32'd16);
    checkOutput("fmtFalls", 32'(frFalls[base]), 32'd16);
    w = frBits[base + 1];
    checkOutput("pwrWord", 32'(w[15:0]), 32'h2D08);
    checkOutput("pwrBits", 32'(frCnt[base + 1]), 32'd16);
    checkOutput("pwrFalls", 32'(frFalls[base + 1]), 32'd16);
    checkOutput("initDoneEdge", 32'(initRiseA), 32'(frEnd[base + 1]));
  endtask

  initial begin
    logic [23:0] w;
    int base, cyc, minBusy, spacingB;
    bit found;

    rst  = 1'b0;
    sdiA = 1'b0;
    sdiB = 1'b0;
    applyStimulus();

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstSCLK", 32'(sclkA), 32'd1);
    checkOutput("rstSS", 32'(ssA), 32'd1);
    checkOutput("rstSDO", 32'(sdoA), 32'd0);
    checkOutput("rstACL", 32'(aclA), 32'd0);
    checkOutput("rstValid", 32'(validA), 32'd0);
    checkOutput("rstInit", 32'(initA), 32'd0);
    rst = 1'b1;

    // Configuration writes
    waitFrames(2);
    @(negedge clk);
    checkInitFrames(0);
    checkOutput("initHigh", 32'(initA), 32'd1);

    // Boundary patterns, then random samples
    waitValid(3);
    for (int k = 2; k < 5; k++) begin
      w = frBits[k];
      checkOutput("readCmd", 32'(w[23:16]), 32'hF4);
      checkOutput("readBits", 32'(frCnt[k]), 32'd24);
      checkOutput("readFalls", 32'(frFalls[k]), 32'd24);
    end
    checkOutput("firstRead", 32'(frStart[2] - initRiseA), 32'(P_A * CLK_P));
    checkOutput("readSpacing1", 32'(frStart[3] - frStart[2]), 32'(P_A * CLK_P));
    checkOutput("readSpacing2", 32'(frStart[4] - frStart[3]), 32'(P_A * CLK_P));
    for (int k = 0; k < 4; k++) begin
      checkOutput("ssGap", 32'((frStart[k + 1] - frEnd[k]) >= 2 * CLK_DIV * CLK_P), 32'd1);
    end
    waitValid(10);
    checkOutput("sclkPeriodErrors", 32'(periodErr), 32'd0);

    // Instance B: a read lasts longer than one period, so every other tick is
    // lost and reads are spaced by the next period multiple after a busy read.
    minBusy  = (1 + (2 * 24 - 1) + 1 + 2) * CLK_DIV;
    spacingB = P_B * ((minBusy + P_B - 1) / P_B);
    checkOutput("bFramesSeen", 32'(bCntQ.size() >= 6), 32'd1);
    if (bCntQ.size() >= 6) begin
      checkOutput("bFirstRead", 32'(bStartQ[2] - initRiseB), 32'(P_B * CLK_P));
      for (int k = 2; k < 6; k++) begin
        checkOutput("bReadBits", 32'(bCntQ[k]), 32'd24);
        checkOutput("bReadCmd", 32'(bCmdQ[k]), 32'hF2);
        if (k > 2) checkOutput("bReadSpacing", 32'(bStartQ[k] - bStartQ[k - 1]), 32'(spacingB * CLK_P));
      end
    end

    // Reset in the middle of a read, with SCLK low just after bit 10
    found = 0;
    cyc   = 0;
    while (!found && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      if (ssA === 1'b0 && fCnt == 10 && sclkA === 1'b0 && frBits.size() >= 2) found = 1;
    end
    checkOutput("midReadFound", 32'(found), 32'd1);
    #1;
    checkOutput("preResetSS", 32'(ssA), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("asyncSS", 32'(ssA), 32'd1);
    checkOutput("asyncSCLK", 32'(sclkA), 32'd1);
    checkOutput("asyncSDO", 32'(sdoA), 32'd0);
    checkOutput("asyncACL", 32'(aclA), 32'd0);
    checkOutput("asyncInit", 32'(initA), 32'd0);
    expQ.delete();
    repeat (3) @(negedge clk);
    base = frBits.size();
    checkOutput("truncatedFrame", 32'(frCnt[base - 1] < 24), 32'd1);
    rst = 1'b1;

    // Full init sequence again, then the first read one period later
    waitFrames(base + 2);
    @(negedge clk);
    checkInitFrames(base);
    waitValid(nValid + 1);
    checkOutput("reinitFirstRead", 32'(frStart[base + 2] - initRiseA), 32'(P_A * CLK_P));
    checkOutput("reinitReadBits", 32'(frCnt[base + 2]), 32'd24);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/acl_spi_reader.md
Name: acl_spi_reader

Overview:
- SPI master that brings up one ADXL345-class accelerometer and samples one axis periodically.
- Delivers the sample as the 10-bit two's-complement ACL word consumed by xvga (ACL1/ACL2); one instance per player.
- Sits between the Pmod accelerometer pins and the VGA/game logic, in the 100 MHz clk domain.

Parameters:
- CLK_DIV, 50: clk cycles per SCLK half-period (100 MHz / 100 = 1 MHz SCLK); minimum 2.
- SAMPLE_PERIOD, 100000: clk cycles between read starts once initialised (1 kHz); must exceed one read transaction.
- AXIS, 1: 0 = X (register 0x32), 1 = Y (register 0x34).

Ports:
- clk  in  1  100 MHz system clock.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- SDI  in  1  MISO from the sensor.
- SDO  out  1  MOSI to the sensor.
- SCLK  out  1  SPI clock, mode 3 (idle high).
- SS  out  1  chip select, active-low.
- ACL_OUT  out  10  latest axis sample, two's complement.
- data_valid  out  1  one-cycle pulse when ACL_OUT updates.
- init_done  out  1  high once both configuration writes have completed.

Behaviour:
- Reset (rst=0, asynchronous):
  - SCLK=1, SS=1, SDO=0, ACL_OUT=0, data_valid=0, init_done=0.
  - FSM=INIT_FMT; sample timer=0.
  - Asserting reset mid-transaction aborts it immediately; SS and SCLK return high without waiting for clk.
- Shift engine:
  - SS falls, then CLK_DIV cycles later the first SCLK falling edge drives the MSB on SDO.
  - Each following rising edge, CLK_DIV cycles after a fall, samples SDI, MSB first.
  - After the final rising edge, SS rises CLK_DIV cycles later. SS then stays high for at least 2*CLK_DIV cycles before the next transaction.
  - SDO returns to 0 when SS is high.
- FSM states:
  - INIT_FMT: 16-bit write {0x31, 0x00} (DATA_FORMAT, ±2 g, 10-bit right-justified).
  - INIT_PWR: 16-bit write {0x2D, 0x08} (POWER_CTL measure).
  - WAIT: idle; read starts on sample-timer terminal count.
  - READ: 24-bit transaction.
    - Command byte = 0xC0 | addr (read + multibyte): 0xF2 for X, 0xF4 for Y.
    - Byte 2 = DATA0, byte 3 = DATA1.
  - UPDATE: one cycle. ACL_OUT <= {DATA1[1:0], DATA0}, data_valid=1, then return to WAIT.
- Transitions: INIT_FMT -> INIT_PWR -> WAIT -> READ -> UPDATE -> WAIT.
- init_done:
  - Rises on the cycle SS deasserts after INIT_PWR.
  - Stays high until reset.
- Sample timer:
  - Counts 0..SAMPLE_PERIOD-1 only while init_done=1, then wraps.
  - The terminal count starts a READ if the FSM is in WAIT. If a READ is still busy, that tick is dropped, not queued.
  - The first read starts SAMPLE_PERIOD cycles after init_done rises.
- Data handling:
  - DATA1[7:2] is ignored (sign extension from the device).
  - ACL_OUT holds its value between updates and never changes without data_valid.
- Latency: last SCLK rising edge of a READ -> ACL_OUT/data_valid within CLK_DIV+2 clk cycles.
- Bit counter width: 5 bits (max 24). SCLK divider width covers CLK_DIV-1.

Test Plan:
- Release reset with CLK_DIV=2, SAMPLE_PERIOD=200 -> SDO carries 0x31,0x00 in SS frame 1 and 0x2D,0x08 in frame 2, 16 SCLK falls each. init_done=1 after frame 2; SCLK period = 4 clk.
- AXIS=1, slave model returns DATA0=0x5A, DATA1=0x03 -> command byte 0xF4, 24 SCLK falls, ACL_OUT=0x35A, single-cycle data_valid.
- Slave returns 0x00, 0xFE -> ACL_OUT=0x200 (most negative). Slave returns 0xFF, 0xFF -> ACL_OUT=0x3FF (-1); upper DATA1 bits ignored.
- Steady state -> read starts spaced exactly 200 clk apart. SS high for at least 4 clk between frames. No data_valid outside UPDATE.
- Set SAMPLE_PERIOD=60, shorter than one read -> overlapping ticks dropped. Every read remains 24 bits; no truncated frames.
- Assert rst mid-READ (bit 10) -> SS=1, SCLK=1 asynchronously; ACL_OUT=0, init_done=0. After release, the full init sequence repeats.
